debounce_sync: RTL and testbench

- Input conditioner for a raw asynchronous level signal, such as a push-button or an external strobe.
- Synchronises the signal into the `clk` domain and filters glitches with a saturating-counter state machine.
- Presents a clean, glitch-free level plus single-cycle edge pulses.
- Sits directly upstream of the team's D flip-flop and register stages: `dout` is the qualified data that feeds their `d` input.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync_chain.sv | 26 ++
 rtl/debounce_sync.sv | 122 ++++++++++++
 tb/tb_debounce_sync.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the debounce/synchroniser input conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_t;

    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single-bit clock-domain crossing.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level and qualifies it with a saturating stability
// counter, producing a clean level plus registered one-cycle rise/fall pulses.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic din_async,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("debounce_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             w_s;
    logic             w_cnt_last;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_async),
        .q   (w_s)
    );

    // True when the current cycle is the final qualifying one.
    assign w_cnt_last = (r_cnt + CNT_ONE) == CNT_DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LOW: begin
                    if (w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state <= STABLE_HIGH;
                            r_dout  <= 1'b1;
                            r_rise  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= WAIT_HIGH;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!w_s) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_state <= STABLE_HIGH;
                        r_dout  <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            r_state <= STABLE_LOW;
                            r_dout  <= 1'b0;
                            r_fall  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= WAIT_LOW;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (w_s) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                    end else if (w_cnt_last) begin
                        r_state <= STABLE_LOW;
                        r_dout  <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance (2 stages, 8 cycles) and a
// fast instance (3 stages, 1 cycle) sharing clock and reset.
module tb_debounce_sync;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic din_a = 1'b0;
    logic din_b = 1'b0;
    logic dout_a, rise_a, fall_a, busy_a;
    logic dout_b, rise_b, fall_b, busy_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din_async (din_a),
        .dout      (dout_a),
        .rise      (rise_a),
        .fall      (fall_a),
        .busy      (busy_a)
    );

    debounce_sync #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .din_async (din_b),
        .dout      (dout_b),
        .rise      (rise_b),
        .fall      (fall_b),
        .busy      (busy_b)
    );

    // Advance past the next posedge; inputs driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_rise, exp_dout, exp_busy;
        #2;
        rst   = 1'b0;
        din_a = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({dout_a, rise_a, fall_a, busy_a} !== 4'b0000)
            $display("FAIL reset_hold: got d/r/f/b=%b want 0000",
                     {dout_a, rise_a, fall_a, busy_a});
        else n_pass++;
        rst = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_rise = (i == 10);
            exp_dout = (i >= 10);
            exp_busy = (i >= 3 && i < 10);
            n_checks++;
            if (rise_a !== exp_rise)
                $display("FAIL reset_release_rise edge %0d: got %b want %b", i, rise_a, exp_rise);
            else n_pass++;
            n_checks++;
            if (dout_a !== exp_dout)
                $display("FAIL reset_release_dout edge %0d: got %b want %b", i, dout_a, exp_dout);
            else n_pass++;
            n_checks++;
            if (busy_a !== exp_busy)
                $display("FAIL reset_release_busy edge %0d: got %b want %b", i, busy_a, exp_busy);
            else n_pass++;
        end
    endtask

    task automatic test_clean_edge(input logic level);
        logic exp_rise, exp_fall, exp_dout, exp_busy;
        din_a = level;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_rise = level && (i == 10);
            exp_fall = !level && (i == 10);
            exp_dout = (i >= 10) ? level : !level;
            exp_busy = (i >= 3 && i < 10);
            n_checks++;
            if ({rise_a, fall_a} !== {exp_rise, exp_fall})
                $display("FAIL clean_%0d_pulses edge %0d: got r/f=%b%b want %b%b", level, i,
                         rise_a, fall_a, exp_rise, exp_fall);
            else n_pass++;
            n_checks++;
            if (dout_a !== exp_dout)
                $display("FAIL clean_%0d_dout edge %0d: got %b want %b", level, i, dout_a, exp_dout);
            else n_pass++;
            n_checks++;
            if (busy_a !== exp_busy)
                $display("FAIL clean_%0d_busy edge %0d: got %b want %b", level, i, busy_a, exp_busy);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        logic exp_busy;
        din_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) din_a = 1'b0;
            tick();
            exp_busy = (i >= 3 && i <= 7);
            n_checks++;
            if ({dout_a, rise_a, fall_a} !== 3'b000)
                $display("FAIL glitch_out edge %0d: got d/r/f=%b want 000", i,
                         {dout_a, rise_a, fall_a});
            else n_pass++;
            n_checks++;
            if (busy_a !== exp_busy)
                $display("FAIL glitch_busy edge %0d: got %b want %b", i, busy_a, exp_busy);
            else n_pass++;
        end
        n_checks++;
        if (u_dut.r_cnt !== 4'd0)
            $display("FAIL glitch_cnt: got %0d want 0", u_dut.r_cnt);
        else n_pass++;
    endtask

    task automatic test_restart();
        logic exp_rise, exp_dout, exp_busy;
        din_a = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            if (i == 7) din_a = 1'b0;
            if (i == 8) din_a = 1'b1;
            tick();
            exp_rise = (i == 17);
            exp_dout = (i >= 17);
            exp_busy = (i >= 3 && i <= 8) || (i >= 10 && i <= 16);
            n_checks++;
            if (rise_a !== exp_rise)
                $display("FAIL restart_rise edge %0d: got %b want %b", i, rise_a, exp_rise);
            else n_pass++;
            n_checks++;
            if (dout_a !== exp_dout)
                $display("FAIL restart_dout edge %0d: got %b want %b", i, dout_a, exp_dout);
            else n_pass++;
            n_checks++;
            if (busy_a !== exp_busy)
                $display("FAIL restart_busy edge %0d: got %b want %b", i, busy_a, exp_busy);
            else n_pass++;
        end
        din_a = 1'b0;
        repeat (12) tick();
        n_checks++;
        if (dout_a !== 1'b0)
            $display("FAIL restart_return_low: got %b want 0", dout_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic exp_rise, exp_dout;
        din_a = 1'b1;
        repeat (7) tick();
        n_checks++;
        if (busy_a !== 1'b1 || u_dut.r_cnt !== 4'd5)
            $display("FAIL midreset_pre: got busy=%b cnt=%0d want busy=1 cnt=5",
                     busy_a, u_dut.r_cnt);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dout_a, rise_a, fall_a, busy_a} !== 4'b0000)
            $display("FAIL midreset_outputs: got d/r/f/b=%b want 0000",
                     {dout_a, rise_a, fall_a, busy_a});
        else n_pass++;
        tick();
        rst = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_rise = (i == 10);
            exp_dout = (i >= 10);
            n_checks++;
            if (rise_a !== exp_rise)
                $display("FAIL midreset_rise edge %0d: got %b want %b", i, rise_a, exp_rise);
            else n_pass++;
            n_checks++;
            if (dout_a !== exp_dout)
                $display("FAIL midreset_dout edge %0d: got %b want %b", i, dout_a, exp_dout);
            else n_pass++;
        end
    endtask

    task automatic test_single_cycle();
        logic exp_pulse, exp_dout;
        for (int lv = 1; lv >= 0; lv--) begin
            din_b = lv[0];
            for (int i = 1; i <= 6; i++) begin
                tick();
                exp_pulse = (i == 4);
                exp_dout  = (i >= 4) ? lv[0] : !lv[0];
                n_checks++;
                if ((lv == 1 ? rise_b : fall_b) !== exp_pulse)
                    $display("FAIL fast_pulse lvl %0d edge %0d: got r/f=%b%b want pulse %b",
                             lv, i, rise_b, fall_b, exp_pulse);
                else n_pass++;
                n_checks++;
                if ((lv == 1 ? fall_b : rise_b) !== 1'b0)
                    $display("FAIL fast_opposite lvl %0d edge %0d: got r/f=%b%b want 0",
                             lv, i, rise_b, fall_b);
                else n_pass++;
                n_checks++;
                if (dout_b !== exp_dout)
                    $display("FAIL fast_dout lvl %0d edge %0d: got %b want %b", lv, i,
                             dout_b, exp_dout);
                else n_pass++;
                n_checks++;
                if (busy_b !== 1'b0)
                    $display("FAIL fast_busy lvl %0d edge %0d: got %b want 0", lv, i, busy_b);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge(1'b0);
        test_clean_edge(1'b1);
        test_clean_edge(1'b0);
        test_glitch();
        test_restart();
        test_reset_mid();
        test_single_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
